// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding and baud constants for the UART transmit arbiter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT_BUSY = 2'd2, WAIT_DONE = 2'd3} state_t;
  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD = 115_200;
  localparam int BAUD_CLK_TICKS = CLK_HZ / BAUD;
endpackage

// File: rtl/uart_rr_picker.sv
// uart_rr_picker: combinational winner select, round-robin after last, or lowest index
// when UART_ARB_FIXED_PRIO_EN is defined.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               valid,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx
);
`ifdef UART_ARB_FIXED_PRIO_EN
  logic unused_last;
  assign unused_last = ^last;
  always_comb begin
    valid = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[IW'(i)]) begin
        valid = 1'b1;
        idx = IW'(i);
      end
  end
`else
  int k;
  // scan offsets high to low so the nearest requester after last wins
  always_comb begin
    k = 0;
    valid = 1'b0;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = int'(last) + 1 + i;
      k = (k >= NUM_REQ) ? k - NUM_REQ : k;
      if (req[IW'(k)]) begin
        valid = 1'b1;
        idx = IW'(k);
      end
    end
  end
`endif
  assign onehot = valid ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [NUM_REQ*8-1:0]       i_data,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic                       o_tx_start,
  output logic [7:0]                 o_tx_data,
  input  logic                       i_tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_owner,
  output logic                       o_active,
  output logic                       o_timeout
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] last, pick_idx;
  logic [NUM_REQ-1:0] pick_oh;
  logic pick_valid, grant;
  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req(i_req),
    .last(last),
    .valid(pick_valid),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    grant = 1'b0;
    o_timeout = 1'b0;
    case (state)
      IDLE: begin
        grant = pick_valid;
        state_n = pick_valid ? LAUNCH : IDLE;
      end
      LAUNCH: begin
        state_n = WAIT_BUSY;
        cnt_n = CW'(BUSY_TIMEOUT - 1);
      end
      WAIT_BUSY: begin
        o_timeout = !i_tx_busy && cnt == '0;
        state_n = i_tx_busy ? WAIT_DONE : (o_timeout ? IDLE : WAIT_BUSY);
        cnt_n = (i_tx_busy || o_timeout) ? cnt : cnt - 1'b1;
      end
      default: state_n = i_tx_busy ? WAIT_DONE : IDLE;
    endcase
  end
  assign o_tx_start = state == LAUNCH;
  assign o_active = state != IDLE;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      last <= IW'(NUM_REQ - 1);
      o_gnt <= '0;
      o_tx_data <= '0;
      o_owner <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      o_gnt <= grant ? pick_oh : '0;
      if (grant) begin
        last <= pick_idx;
        o_owner <= pick_idx;
        o_tx_data <= i_data[8*pick_idx +: 8];
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_uart_tx_arbiter;
  localparam int N = 4;
  localparam int TO = 1024;
  logic clk = 1'b0, rst = 1'b1, busy = 1'b0;
  logic [N-1:0] req = '0;
  logic [8*N-1:0] data = '0;
  logic [N-1:0] gnt;
  logic start, active, tmo;
  logic [7:0] txd;
  logic [1:0] owner;
  int tests = 0, fails = 0, cyc = 0, n_start = 0;
  int gq[$];
  int dq[$];
  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_data(data), .o_gnt(gnt),
    .o_tx_start(start), .o_tx_data(txd), .i_tx_busy(busy), .o_owner(owner),
    .o_active(active), .o_timeout(tmo)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int off = 1; off <= N; off++) if (r[(last + off) % N]) return (last + off) % N;
`endif
    return -1;
  endfunction
  // model: a transfer is "age" cycles past its start pulse; it ends on busy fall or at age TO
  bit m_ok = 0, m_act = 0, m_seen = 0;
  int m_age = 0, m_last = N - 1, m_owner = 0;
  logic [7:0] m_data = '0;
  always @(posedge clk) begin
    int w;
    w = pick(req, m_last);
    if (rst) begin
      m_ok = 1; m_act = 0; m_last = N - 1; m_owner = 0; m_data = '0;
    end else if (!m_act) begin
      if (w >= 0) begin
        m_act = 1; m_age = 0; m_seen = 0; m_owner = w; m_last = w; m_data = data[8*w +: 8];
      end
    end else if (m_age == 0) m_age = 1;
    else if (!m_seen) begin
      if (busy) m_seen = 1;
      else if (m_age == TO) m_act = 0;
      else m_age++;
    end else if (!busy) m_act = 0;
  end
  always @(negedge clk) if (m_ok) begin
    logic [N-1:0] eg;
    eg = (m_act && m_age == 0) ? 4'(1) << m_owner : '0;
    chk("gnt", gnt, eg);
    chk("tx_start", start, m_act && m_age == 0);
    chk("active", active, m_act);
    chk("timeout", tmo, m_act && !m_seen && m_age == TO && !busy);
    chk("tx_data", txd, m_data);
    chk("owner", owner, m_owner);
  end
  always @(negedge clk) begin
    if (start === 1'b1) n_start++;
    if (|gnt === 1'b1) begin gq.push_back(owner); dq.push_back(txd); end
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic do_reset(input logic [N-1:0] r);
    rst = 1; busy = 0; req = r; step(); rst = 0; gq.delete(); dq.delete();
  endtask
  task automatic wait_start(output int c);
    for (int k = 0; k < 50 && start !== 1'b1; k++) step();
    chk("start_seen", start, 1);
    c = cyc;
  endtask
  task automatic xfer(input int len);
    int c;
    wait_start(c);
    step(2); busy = 1; step(len); busy = 0;
  endtask
  initial begin
    int cs;
    data = 32'h13121110;
    step(2);
    chk("rst_gnt", gnt, 0); chk("rst_start", start, 0); chk("rst_active", active, 0);
    chk("rst_tmo", tmo, 0); chk("rst_data", txd, 0); chk("rst_owner", owner, 0);
    rst = 0; data[7:0] = 8'h55; req = 4'b0001;
    wait_start(cs);
    chk("single_gnt", gnt, 4'b0001); chk("single_data", txd, 8'h55);
    req = 0; step(2); busy = 1; step(8680); busy = 0;
    chk("single_busy_active", active, 1);
    step(); chk("single_active_fall", active, 0);
    step(5); chk("single_starts", n_start, 1);
    data = 32'h13121110;
    do_reset(4'hF);
    repeat (5) xfer(20);
    chk("rr_count", gq.size() >= 5, 1);
    for (int i = 0; i < 5 && i < gq.size(); i++) begin
      chk("rr_owner", gq[i], i % 4); chk("rr_data", dq[i], 8'h10 + i % 4);
    end
    do_reset(4'b1010);
    repeat (3) xfer(20);
    chk("prio_count", gq.size() >= 3, 1);
    for (int i = 0; i < 3 && i < gq.size(); i++)
`ifdef UART_ARB_FIXED_PRIO_EN
      chk("prio_owner", gq[i], 1);
`else
      chk("prio_owner", gq[i], (i % 2) ? 3 : 1);
`endif
    do_reset(4'b0001);
    wait_start(cs); req = 0;
    for (int k = 0; k < 1100 && tmo !== 1'b1; k++) step();
    chk("tmo_seen", tmo, 1); chk("tmo_delay", cyc - cs, TO);
    step(); chk("tmo_idle", active, 0);
    req = 4'b0010; wait_start(cs); chk("tmo_regrant", gnt, 4'b0010);
    do_reset(4'b0111);
    xfer(20);
    wait_start(cs); chk("mid_owner1", owner, 1);
    step(2); busy = 1; step(10);
    rst = 1; step();
    chk("mid_gnt", gnt, 0); chk("mid_start", start, 0); chk("mid_active", active, 0);
    chk("mid_owner", owner, 0); chk("mid_data", txd, 0); chk("mid_tmo", tmo, 0);
    rst = 0; busy = 0;
    wait_start(cs); chk("mid_regrant", gnt, 4'b0001);
    do_reset(4'b0001);
    wait_start(cs); req = 0; step(2); busy = 1; step(5);
    req = 4'b0100; step(20);
    chk("late_nogrant", gq.size(), 1); chk("late_active", active, 1);
    busy = 0; step();
    chk("late_idle_gnt", gnt, 0); chk("late_idle_active", active, 0);
    step(); chk("late_gnt", gnt, 4'b0100); chk("late_owner", owner, 2);
    do_reset(4'b0000);
    step(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
